// File: rtl/friscv_cache_pkg.sv
// Shared definitions for the cache miss/flush machinery: AXI encodings,
// fetcher state encoding and geometry helpers.
package friscv_cache_pkg;

  localparam logic [1:0] AXI_INCR = 2'b01;
  localparam logic [1:0] AXI_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AR    = 3'd1,
    ST_R     = 3'd2,
    ST_WRITE = 3'd3,
    ST_FLUSH = 3'd4
  } fetcher_state_t;

  function automatic int calc_beats(input int block_w, input int data_w);
    return block_w / data_w;
  endfunction

  function automatic int calc_index_ix(input int block_w);
    return $clog2(block_w / 8);
  endfunction

  function automatic int calc_axi_size(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/friscv_cache_line_fetcher.sv
// Cache miss handler: fetches one aligned line with a single AXI4 INCR burst,
// writes it into the cache blocks, and runs the full-index flush sweep.
module friscv_cache_line_fetcher
  import friscv_cache_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int AXI_ID_W      = 8,
  parameter int AXI_ID        = 'h10,
  parameter int AXI_DATA_W    = 32,
  parameter int CACHE_BLOCK_W = 128,
  parameter int CACHE_DEPTH   = 512
)(
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       srst,
  input  logic                       flush_req,
  output logic                       flush_ack,
  input  logic                       miss_valid,
  output logic                       miss_ready,
  input  logic [ADDR_W-1:0]          miss_addr,
  output logic                       fetch_done,
  output logic                       fetch_err,
  output logic                       arvalid,
  input  logic                       arready,
  output logic [ADDR_W-1:0]          araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic [AXI_ID_W-1:0]        arid,
  input  logic                       rvalid,
  output logic                       rready,
  input  logic [AXI_ID_W-1:0]        rid,
  input  logic [1:0]                 rresp,
  input  logic [AXI_DATA_W-1:0]      rdata,
  input  logic                       rlast,
  output logic                       cache_wen,
  output logic [ADDR_W-1:0]          cache_waddr,
  output logic [CACHE_BLOCK_W-1:0]   cache_wdata,
  output logic [CACHE_BLOCK_W/8-1:0] cache_wstrb,
  output logic                       cache_flush
);

  localparam int BEATS    = calc_beats(CACHE_BLOCK_W, AXI_DATA_W);
  localparam int INDEX_IX = calc_index_ix(CACHE_BLOCK_W);
  localparam int STRB_W   = CACHE_BLOCK_W / 8;
  localparam int IDX_W    = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;

  localparam logic [7:0]          LAST_BEAT = 8'(BEATS - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(CACHE_DEPTH - 1);
  localparam logic [ADDR_W-1:0]   LINE_MASK = ~(ADDR_W'((1 << INDEX_IX) - 1));
  localparam logic [AXI_ID_W-1:0] MY_ID     = AXI_ID_W'(AXI_ID);

  fetcher_state_t             state_r, state_s;
  logic [ADDR_W-1:0]          base_r, base_s;
  logic [CACHE_BLOCK_W-1:0]   line_r, line_s;
  logic                       err_r, err_s;
  logic [7:0]                 beat_r, beat_s;
  logic [IDX_W-1:0]           idx_r, idx_s;
  logic                       beat_bad_s;

  logic                       miss_ready_r, miss_ready_s;
  logic                       arvalid_r, arvalid_s;
  logic                       rready_r, rready_s;
  logic                       cache_wen_r, cache_wen_s;
  logic [ADDR_W-1:0]          cache_waddr_r, cache_waddr_s;
  logic [CACHE_BLOCK_W-1:0]   cache_wdata_r, cache_wdata_s;
  logic [STRB_W-1:0]          cache_wstrb_r, cache_wstrb_s;
  logic                       cache_flush_r, cache_flush_s;
  logic                       fetch_done_r, fetch_done_s;
  logic                       fetch_err_r, fetch_err_s;
  logic                       flush_ack_r, flush_ack_s;

  // Next-state and next-output logic; srst is folded in here so the flops only see aresetn
  always_comb begin
    state_s       = state_r;
    base_s        = base_r;
    line_s        = line_r;
    err_s         = err_r;
    beat_s        = beat_r;
    idx_s         = idx_r;
    cache_waddr_s = cache_waddr_r;
    cache_wen_s   = 1'b0;
    cache_wdata_s = '0;
    cache_wstrb_s = '0;
    cache_flush_s = 1'b0;
    fetch_done_s  = 1'b0;
    fetch_err_s   = 1'b0;
    flush_ack_s   = 1'b0;
    miss_ready_s  = 1'b0;
    arvalid_s     = 1'b0;
    rready_s      = 1'b0;
    beat_bad_s    = (rresp != AXI_OKAY) || (rid != MY_ID) ||
                    (rlast && (beat_r != LAST_BEAT));

    if (srst) begin
      state_s       = ST_IDLE;
      base_s        = '0;
      line_s        = '0;
      err_s         = 1'b0;
      beat_s        = 8'd0;
      idx_s         = '0;
      cache_waddr_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A miss handshake already made visible by miss_ready is honoured;
          // a flush raised in that same cycle is served after the fetch.
          if (miss_valid && miss_ready_r) begin
            state_s = ST_AR;
            base_s  = miss_addr & LINE_MASK;
            err_s   = 1'b0;
            beat_s  = 8'd0;
          end else if (flush_req) begin
            state_s = ST_FLUSH;
            idx_s   = '0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_AR: begin
          if (arready) begin
            state_s = ST_R;
          end else begin
            state_s = ST_AR;
          end
        end
        ST_R: begin
          if (rvalid && rready_r) begin
            line_s[beat_r*AXI_DATA_W +: AXI_DATA_W] = rdata;
            err_s = err_r | beat_bad_s;
            if (beat_r == LAST_BEAT) begin
              state_s       = ST_WRITE;
              cache_wen_s   = ~err_s;
              cache_waddr_s = base_r;
              cache_wdata_s = line_s;
              cache_wstrb_s = {STRB_W{1'b1}};
              fetch_done_s  = 1'b1;
              fetch_err_s   = err_s;
            end else begin
              beat_s = beat_r + 8'd1;
            end
          end else begin
            state_s = ST_R;
          end
        end
        ST_WRITE: begin
          state_s = ST_IDLE;
        end
        ST_FLUSH: begin
          if (idx_r == LAST_IDX) begin
            state_s = ST_IDLE;
          end else begin
            idx_s = idx_r + 1'b1;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase

      // Sweep write for the index that will be current next cycle
      if (state_s == ST_FLUSH) begin
        cache_wen_s   = 1'b1;
        cache_flush_s = 1'b1;
        cache_waddr_s = ADDR_W'(idx_s) << INDEX_IX;
        cache_wdata_s = '0;
        cache_wstrb_s = {STRB_W{1'b1}};
        flush_ack_s   = (idx_s == LAST_IDX);
      end else begin
        cache_flush_s = 1'b0;
      end

      miss_ready_s = (state_s == ST_IDLE) && !flush_req;
      arvalid_s    = (state_s == ST_AR);
      rready_s     = (state_s == ST_R) || (state_s == ST_IDLE);
    end
  end

  // FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers and registered outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      base_r        <= '0;
      line_r        <= '0;
      err_r         <= 1'b0;
      beat_r        <= 8'd0;
      idx_r         <= '0;
      miss_ready_r  <= 1'b0;
      arvalid_r     <= 1'b0;
      rready_r      <= 1'b0;
      cache_wen_r   <= 1'b0;
      cache_waddr_r <= '0;
      cache_wdata_r <= '0;
      cache_wstrb_r <= '0;
      cache_flush_r <= 1'b0;
      fetch_done_r  <= 1'b0;
      fetch_err_r   <= 1'b0;
      flush_ack_r   <= 1'b0;
    end else begin
      base_r        <= base_s;
      line_r        <= line_s;
      err_r         <= err_s;
      beat_r        <= beat_s;
      idx_r         <= idx_s;
      miss_ready_r  <= miss_ready_s;
      arvalid_r     <= arvalid_s;
      rready_r      <= rready_s;
      cache_wen_r   <= cache_wen_s;
      cache_waddr_r <= cache_waddr_s;
      cache_wdata_r <= cache_wdata_s;
      cache_wstrb_r <= cache_wstrb_s;
      cache_flush_r <= cache_flush_s;
      fetch_done_r  <= fetch_done_s;
      fetch_err_r   <= fetch_err_s;
      flush_ack_r   <= flush_ack_s;
    end
  end

  assign miss_ready  = miss_ready_r;
  assign arvalid     = arvalid_r;
  assign araddr      = base_r;
  assign arlen       = LAST_BEAT;
  assign arsize      = 3'(calc_axi_size(AXI_DATA_W));
  assign arburst     = AXI_INCR;
  assign arid        = MY_ID;
  assign rready      = rready_r;
  assign cache_wen   = cache_wen_r;
  assign cache_waddr = cache_waddr_r;
  assign cache_wdata = cache_wdata_r;
  assign cache_wstrb = cache_wstrb_r;
  assign cache_flush = cache_flush_r;
  assign fetch_done  = fetch_done_r;
  assign fetch_err   = fetch_err_r;
  assign flush_ack   = flush_ack_r;

endmodule

// File: tb/tb_friscv_cache_line_fetcher.sv
// Randomized bench for the line fetcher: a procedural AXI slave plus a line/error
// model built from the beat stream, and a flush-sweep address model.
module tb_friscv_cache_line_fetcher;

  localparam int ADDR_W        = 32;
  localparam int AXI_ID_W      = 8;
  localparam int AXI_ID        = 'h10;
  localparam int AXI_DATA_W    = 32;
  localparam int CACHE_BLOCK_W = 128;
  localparam int CACHE_DEPTH   = 512;
  localparam int BEATS         = CACHE_BLOCK_W / AXI_DATA_W;
  localparam int STRB_W        = CACHE_BLOCK_W / 8;

  logic                     aclk, aresetn, srst;
  logic                     flush_req, flush_ack;
  logic                     miss_valid, miss_ready;
  logic [ADDR_W-1:0]        miss_addr;
  logic                     fetch_done, fetch_err;
  logic                     arvalid, arready;
  logic [ADDR_W-1:0]        araddr;
  logic [7:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic [AXI_ID_W-1:0]      arid;
  logic                     rvalid, rready;
  logic [AXI_ID_W-1:0]      rid;
  logic [1:0]               rresp;
  logic [AXI_DATA_W-1:0]    rdata;
  logic                     rlast;
  logic                     cache_wen;
  logic [ADDR_W-1:0]        cache_waddr;
  logic [CACHE_BLOCK_W-1:0] cache_wdata;
  logic [STRB_W-1:0]        cache_wstrb;
  logic                     cache_flush;

  int vec_cnt = 0;
  int err_cnt = 0;

  friscv_cache_line_fetcher #(
    .ADDR_W(ADDR_W), .AXI_ID_W(AXI_ID_W), .AXI_ID(AXI_ID), .AXI_DATA_W(AXI_DATA_W),
    .CACHE_BLOCK_W(CACHE_BLOCK_W), .CACHE_DEPTH(CACHE_DEPTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .flush_req(flush_req), .flush_ack(flush_ack),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .fetch_done(fetch_done), .fetch_err(fetch_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rresp(rresp), .rdata(rdata), .rlast(rlast),
    .cache_wen(cache_wen), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
    .cache_wstrb(cache_wstrb), .cache_flush(cache_flush)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [CACHE_BLOCK_W-1:0] got,
                           input logic [CACHE_BLOCK_W-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_val(tag, {arvalid, rready, cache_wen, cache_flush, fetch_done, fetch_err,
                    flush_ack, miss_ready, araddr, cache_wdata[31:0]}, '0);
  endtask

  // bad_kind: 1 rresp=SLVERR, 2 wrong rid, 3 rlast toggled, 4 rresp=EXOKAY
  task automatic do_fetch(input logic [31:0] addr, input int ar_dly, input int gap,
                          input int bad_beat, input int bad_kind, input bit directed,
                          input int flush_at_beat);
    logic [CACHE_BLOCK_W-1:0] exp_line;
    logic [31:0] line_addr;
    logic [31:0] d;
    bit exp_err;
    int waited;
    int g;
    exp_line  = '0;
    exp_err   = 1'b0;
    line_addr = addr & 32'hFFFF_FFF0;
    waited    = 0;
    while (!miss_ready && waited < 50) begin
      step();
      waited++;
    end
    check_val("miss_ready_wait", miss_ready, 1'b1);
    miss_valid = 1'b1;
    miss_addr  = addr;
    step();
    miss_valid = 1'b0;
    miss_addr  = $urandom;
    check_val("ar_issue", {arvalid, araddr, arlen, arsize, arburst, arid, miss_ready},
              {1'b1, line_addr, 8'd3, 3'd2, 2'b01, 8'h10, 1'b0});
    for (int i = 0; i < ar_dly; i++) begin
      step();
      check_val("ar_hold", {arvalid, araddr, arlen, arsize, arburst, arid},
                {1'b1, line_addr, 8'd3, 3'd2, 2'b01, 8'h10});
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    check_val("ar_done", arvalid, 1'b0);
    for (int k = 0; k < BEATS; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int j = 0; j < g; j++) begin
        rvalid = 1'b0;
        step();
        check_val("r_gap", {cache_wen, fetch_done, rready}, 3'b001);
      end
      if (flush_at_beat == k) flush_req = 1'b1;
      d      = directed ? 32'h1111_1111 * (k + 1) : $urandom;
      rvalid = 1'b1;
      rdata  = d;
      rid    = 8'h10;
      rresp  = 2'b00;
      rlast  = (k == BEATS - 1);
      if (k == bad_beat) begin
        case (bad_kind)
          1: rresp = 2'b10;
          2: rid   = 8'h10 ^ 8'($urandom_range(1, 255));
          3: rlast = ~rlast;
          4: rresp = 2'b01;
          default: rresp = 2'b00;
        endcase
        exp_err = exp_err | (bad_kind == 1) | (bad_kind == 2) | (bad_kind == 4) |
                  ((bad_kind == 3) && (k != BEATS - 1));
      end
      check_val("rready", rready, 1'b1);
      exp_line[k*AXI_DATA_W +: AXI_DATA_W] = d;
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    check_val("fetch_done", {fetch_done, fetch_err, cache_wen}, {1'b1, exp_err, !exp_err});
    if (!exp_err) begin
      check_val("cache_write", {cache_waddr, cache_wstrb, cache_flush},
                {line_addr, 16'hFFFF, 1'b0});
      check_val("cache_wdata", cache_wdata, exp_line);
    end
    step();
    check_val("post_write", {cache_wen, fetch_done}, 2'b00);
    check_val("miss_ready_after", miss_ready, (flush_at_beat < 0));
  endtask

  task automatic flush_sweep(input bit pre, input bit keep);
    if (!pre) flush_req = 1'b1;
    step();
    for (int i = 0; i < CACHE_DEPTH; i++) begin
      check_val("flush_write",
                {cache_wen, cache_flush, cache_waddr, cache_wstrb, flush_ack, miss_ready},
                {1'b1, 1'b1, 32'(i * 16), 16'hFFFF, (i == CACHE_DEPTH - 1), 1'b0});
      check_val("flush_wdata", cache_wdata, '0);
      if (i == CACHE_DEPTH - 1 && !keep) flush_req = 1'b0;
      step();
    end
    check_val("flush_end", {cache_wen, flush_ack, miss_ready}, {1'b0, 1'b0, !keep});
  endtask

  task automatic stray_beat();
    check_val("idle_rready", rready, 1'b1);
    rvalid = 1'b1;
    rdata  = $urandom;
    rresp  = 2'($urandom_range(0, 3));
    rlast  = 1'b1;
    step();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    check_val("stray_ignored", {cache_wen, fetch_done, arvalid, miss_ready}, 4'b0001);
  endtask

  task automatic abort_fetch(input bit use_srst);
    int waited;
    waited = 0;
    while (!miss_ready && waited < 50) begin
      step();
      waited++;
    end
    miss_valid = 1'b1;
    miss_addr  = $urandom;
    step();
    miss_valid = 1'b0;
    arready    = 1'b1;
    step();
    arready    = 1'b0;
    rvalid     = 1'b1;
    rid        = 8'h10;
    rdata      = $urandom;
    step();
    step();
    rvalid     = 1'b0;
    if (use_srst) begin
      srst = 1'b1;
      step();
      check_quiet("srst_outputs");
      srst = 1'b0;
    end else begin
      aresetn = 1'b0;
      #1;
      check_quiet("arst_outputs");
      step();
      step();
      aresetn = 1'b1;
    end
    step();
    check_val("abort_release", {miss_ready, rready, cache_wen}, 3'b110);
    for (int i = 0; i < 6; i++) begin
      step();
      check_val("abort_no_write", {cache_wen, fetch_done}, 2'b00);
    end
  endtask

  initial begin
    aresetn    = 1'b0;
    srst       = 1'b0;
    flush_req  = 1'b0;
    miss_valid = 1'b0;
    miss_addr  = '0;
    arready    = 1'b0;
    rvalid     = 1'b0;
    rid        = '0;
    rresp      = 2'b00;
    rdata      = '0;
    rlast      = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_quiet("reset_outputs");
    aresetn = 1'b1;
    step();
    check_val("ready_after_reset", {miss_ready, rready}, 2'b11);

    do_fetch(32'h0000_1234, 0, 0, -1, 0, 1'b1, -1);
    do_fetch(32'h0000_1234, 5, 1, -1, 0, 1'b1, -1);
    do_fetch(32'hABCD_0048, 0, 0, 2, 1, 1'b0, -1);
    do_fetch(32'h0000_2000, 0, 0, -1, 0, 1'b0, -1);
    do_fetch(32'h0000_3010, 1, 0, 1, 3, 1'b0, -1);
    do_fetch(32'h0000_4020, 0, 0, BEATS - 1, 3, 1'b0, -1);

    flush_sweep(1'b0, 1'b0);
    do_fetch(32'h8000_0F3C, 1, 0, -1, 0, 1'b0, 1);
    flush_sweep(1'b1, 1'b0);
    flush_sweep(1'b0, 1'b1);
    flush_sweep(1'b1, 1'b0);

    abort_fetch(1'b0);
    abort_fetch(1'b1);

    for (int n = 0; n < 40; n++) begin
      int bad;
      bad = ($urandom_range(0, 3) == 0) ? 1 : 0;
      if ($urandom_range(0, 3) == 0) stray_beat();
      do_fetch($urandom, int'($urandom_range(0, 4)), -1,
               bad ? int'($urandom_range(0, BEATS - 1)) : -1,
               bad ? int'($urandom_range(1, 4)) : 0, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/friscv_cache_line_fetcher.md
# friscv_cache_line_fetcher

Miss handler for the cache block storage. It accepts one miss address at a time, issues a single AXI4 INCR read burst for the aligned cache line, and assembles the returned beats into one line. It then writes that line into the cache blocks through their write port. It also runs the flush sweep, walking every block index and clearing its set bit through the same write port.

## Interface
Parameters:
- ADDR_W, 32, address width
- AXI_ID_W, 8, AXI ID width
- AXI_ID, 'h10, ID driven on ARID and expected on RID
- AXI_DATA_W, 32, AXI read data width
- CACHE_BLOCK_W, 128, line payload in bits; BEATS = CACHE_BLOCK_W/AXI_DATA_W, a power of two from 1 to 256
- CACHE_DEPTH, 512, number of blocks; INDEX_IX = log2(CACHE_BLOCK_W/8)

Ports:
- aclk in 1: clock
- aresetn in 1: asynchronous active-low reset
- srst in 1: synchronous reset, active high
- flush_req in 1: level; requests a full invalidation sweep
- flush_ack out 1: one-cycle pulse on the last sweep write
- miss_valid in 1: miss request valid
- miss_ready out 1: miss request ready
- miss_addr in ADDR_W: address that missed
- fetch_done out 1: one-cycle pulse when the fetch completes
- fetch_err out 1: qualifies fetch_done; 1 means the line was discarded
- arvalid out 1, arready in 1, araddr out ADDR_W, arlen out 8, arsize out 3, arburst out 2, arid out AXI_ID_W: AXI4 read address channel
- rvalid in 1, rready out 1, rid in AXI_ID_W, rresp in 2, rdata in AXI_DATA_W, rlast in 1: AXI4 read data channel
- cache_wen out 1, cache_waddr out ADDR_W, cache_wdata out CACHE_BLOCK_W, cache_wstrb out CACHE_BLOCK_W/8, cache_flush out 1: cache blocks write port

## Operation
- FSM states: IDLE, AR, R, WRITE, FLUSH.
- IDLE:
  - flush_req has priority: go to FLUSH.
  - Otherwise miss_ready=1. On miss_valid&miss_ready, latch line base = miss_addr with bits [INDEX_IX-1:0] cleared, then go to AR.
- AR:
  - arvalid=1 with araddr=line base, arlen=BEATS-1, arsize=log2(AXI_DATA_W/8), arburst=INCR (2'b01), arid=AXI_ID.
  - All AR fields are held stable until arready. On the handshake go to R.
- R:
  - rready=1. Beat k (counter from 0) lands in line[k*AXI_DATA_W +: AXI_DATA_W].
  - Sticky error: set when any beat has rresp!=OKAY or rid!=AXI_ID.
  - On the handshake of beat BEATS-1, go to WRITE; rlast is not used for termination.
  - rlast asserted on any other beat sets the error flag.
- WRITE (1 cycle):
  - No error: cache_wen=1, cache_waddr=line base, cache_wdata=line, cache_wstrb=all ones, cache_flush=0.
  - Error: cache_wen=0.
  - fetch_done=1 and fetch_err=error flag; go to IDLE.
- FLUSH:
  - One write per cycle for idx = 0..CACHE_DEPTH-1: cache_wen=1, cache_flush=1, cache_waddr = idx<<INDEX_IX, cache_wdata=0, cache_wstrb=all ones.
  - flush_ack=1 on idx=CACHE_DEPTH-1, then go to IDLE.
- flush_req arriving during AR/R/WRITE waits; it is served on the first IDLE cycle after the fetch.
- In IDLE, rready=1 and stray beats are discarded with no effect.

## Timing
- Reset values (aresetn low or srst high): state IDLE; arvalid, rready, cache_wen, cache_flush, fetch_done, fetch_err, flush_ack, miss_ready all 0. Address and data registers are 0.
- miss_ready rises the cycle after reset is released.
- srst mid-operation aborts immediately: no cache write, no fetch_done. The interconnect must be quiescent or drained by IDLE rready.
- Miss accepted at cycle T: arvalid at T+1.
- Last R beat at cycle U: cache_wen and fetch_done at U+1; miss_ready at U+2.
- Minimum miss-to-write latency with zero-wait AXI: BEATS+2 cycles.
- Flush sweep: exactly CACHE_DEPTH cycles of cache_wen. It starts the cycle after flush_req is seen in IDLE.
- flush_req still high after flush_ack starts a new sweep. The requester drops flush_req on flush_ack.
- All outputs are registered; no combinational path from AXI inputs to AXI outputs.

## Structure
- Shared package friscv_cache_pkg holds:
  - AXI encodings: INCR=2'b01, OKAY=2'b00.
  - The fetcher state enum.
  - Functions for BEATS and INDEX_IX.
- Single flat module with no sub-module. The beat counter and index counter are plain registers inside it.

## Test plan
- Miss 0x0000_1234, BEATS=4, RDATA 0x11111111..0x44444444, zero wait. Required:
  - araddr=0x1230, arlen=3.
  - cache_wdata=0x44444444_33333333_22222222_11111111, cache_wstrb=16'hFFFF.
  - cache_wen and fetch_done at U+1, fetch_err=0.
- arready delayed 5 cycles and rvalid toggled every other cycle. Required: AR fields stable throughout, same line written, one fetch_done.
- Beat 2 returns rresp=2'b10. Required: no cache_wen, fetch_done=1 with fetch_err=1, next miss accepted normally.
- flush_req raised in IDLE, CACHE_DEPTH=512. Required: 512 consecutive writes with cache_flush=1 at addresses 0x0, 0x10, ..., 0x1FF0, and flush_ack on the 512th.
- flush_req raised during R state. Required: the fetch completes with its write, then the sweep starts on the cycle after the return to IDLE.
- aresetn pulsed low during R. Required: all outputs 0 immediately; after release, miss_ready=1 and no cache_wen.
